// File: rtl/sevenseg_pkg.sv
// Shared glyph constants, FSM state type and BCD sizing for the seven-segment display driver.
// Segment bit order everywhere is {g,f,e,d,c,b,a}, active-high before any pad inversion.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Index 0 is the rightmost entry: 0-9, A, b, C, d, E, F.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Bits needed to hold the decimal form of the largest VALUE_W-bit number.
  function automatic int bcd_width(input int value_w);
    longint unsigned max_val;
    int              digits;
    max_val = (64'd1 << value_w) - 64'd1;
    digits  = 1;
    max_val = max_val / 64'd10;
    while (max_val != 64'd0) begin
      digits  = digits + 1;
      max_val = max_val / 64'd10;
    end
    return 4 * digits;
  endfunction

endpackage

// File: rtl/sevenseg_glyph.sv
// Combinational digit-to-segment decoder; dash overrides blank, blank overrides the hex glyph.
// Zero latency, no flow control.
module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = HEX_GLYPH[i_digit];
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/sevenseg_mux_display.sv
// Multiplexed seven-segment driver: capture, optional double-dabble, atomic commit, digit scan.
// Digits visible 2 cycles after load (hex) or VALUE_W+2 (decimal); load is ignored while busy.
module sevenseg_mux_display
  import sevenseg_pkg::*;
#(
  parameter int VALUE_W      = 8,
  parameter int DIGITS       = 3,
  parameter int REFRESH_DIV  = 1000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               mode_dec,
  input  logic               blank_lz,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  dig_en,
  output logic               busy,
  output logic               ovf
);

  localparam int BCD_W  = bcd_width(VALUE_W);
  localparam int BCD_N  = BCD_W / 4;
  localparam int HEX_W  = 4 * ((VALUE_W + 3) / 4);
  localparam int SRC_W0 = (BCD_W > HEX_W) ? BCD_W : HEX_W;
  localparam int SRC_W  = (SRC_W0 > 4 * DIGITS) ? SRC_W0 : 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int ITER_W = $clog2(VALUE_W + 1);

  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);
  localparam logic [6:0]        POL_SEG   = {7{COMMON_ANODE}};
  localparam logic [DIGITS-1:0] POL_DIG   = {DIGITS{COMMON_ANODE}};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [VALUE_W-1:0]       r_bin;
  logic [BCD_W-1:0]         r_bcd;
  logic [ITER_W-1:0]        r_iter;
  logic                     r_mode_dec;
  logic                     r_blank_lz;
  logic [DIGITS-1:0][3:0]   r_digits;
  logic [DIGITS-1:0]        r_blank;
  logic                     r_ovf;
  logic [IDX_W-1:0]         r_idx;
  logic [PRE_W-1:0]         r_pre;
  logic [6:0]               r_seg;
  logic [DIGITS-1:0]        r_dig_en;

  logic [BCD_W-1:0]         w_bcd_adj;
  logic [SRC_W-1:0]         w_src;
  logic [DIGITS-1:0][3:0]   w_dig_new;
  logic [DIGITS-1:0]        w_blank_new;
  logic                     w_ovf_new;
  logic                     w_seen;
  logic                     w_commit;
  logic [DIGITS-1:0][3:0]   w_disp_dig;
  logic [DIGITS-1:0]        w_disp_blank;
  logic                     w_disp_ovf;
  logic [6:0]               w_glyph;
  logic [DIGITS-1:0]        w_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_nxt = mode_dec ? ST_CONV : ST_COMMIT;
        end
      end
      ST_CONV: begin
        if (r_iter == ITER_LAST) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Hex mode reads the captured value directly; decimal reads the finished BCD register.
  always_comb begin
    w_src = '0;
    if (r_mode_dec) begin
      w_src[BCD_W-1:0] = r_bcd;
    end else begin
      w_src[VALUE_W-1:0] = r_bin;
    end
  end

  always_comb begin
    w_ovf_new   = |(w_src >> (4 * DIGITS));
    w_dig_new   = '0;
    w_blank_new = '0;
    w_seen      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig_new[i] = w_src[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_seen         = w_seen | (w_dig_new[i] != 4'd0);
      w_blank_new[i] = r_blank_lz & ~w_ovf_new & ~w_seen;
    end
  end

  // Bypass during COMMIT so the output register picks up new digits on the same edge they commit.
  assign w_commit     = (r_state == ST_COMMIT);
  assign w_disp_dig   = w_commit ? w_dig_new : r_digits;
  assign w_disp_blank = w_commit ? w_blank_new : r_blank;
  assign w_disp_ovf   = w_commit ? w_ovf_new : r_ovf;
  assign w_onehot     = DIGITS'(1) << r_idx;

  sevenseg_glyph u_glyph (
    .i_digit (w_disp_dig[r_idx]),
    .i_blank (w_disp_blank[r_idx]),
    .i_dash  (w_disp_ovf),
    .o_seg   (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_mode_dec <= 1'b0;
      r_blank_lz <= 1'b0;
      r_digits   <= '0;
      r_blank    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_mode_dec <= mode_dec;
            r_blank_lz <= blank_lz;
          end
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_iter         <= r_iter + ITER_W'(1);
        end
        ST_COMMIT: begin
          r_digits <= w_dig_new;
          r_blank  <= w_blank_new;
          r_ovf    <= w_ovf_new;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_seg    <= POL_SEG;
      r_dig_en <= POL_DIG;
    end else begin
      if (r_pre == PRE_MAX) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_seg    <= w_glyph ^ POL_SEG;
      r_dig_en <= w_onehot ^ POL_DIG;
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;
  assign busy   = (r_state != ST_IDLE);
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_sevenseg_mux_display.sv
// Scoreboard bench: three display instances (3 digits, 2 digits, 3 digits common-anode) share inputs;
// each commit (busy fall or reset release) is checked over one full 12-cycle scan window.
module tb_sevenseg_mux_display;

  typedef struct {
    logic [2:0][6:0] g3;
    logic            ovf3;
    logic [1:0][6:0] g2;
    logic            ovf2;
    int              busy_len;
    int              id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] value;
  logic       load;
  logic       mode_dec;
  logic       blank_lz;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] dig_en_a, dig_en_c;
  logic [1:0] dig_en_b;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;
  int   done_cnt = 0;

  sevenseg_mux_display #(.VALUE_W(8), .DIGITS(3), .REFRESH_DIV(4), .COMMON_ANODE(1'b0)) u_a (
    .clk(clk), .rst(rst), .value(value), .load(load), .mode_dec(mode_dec), .blank_lz(blank_lz),
    .seg(seg_a), .dig_en(dig_en_a), .busy(busy_a), .ovf(ovf_a)
  );

  sevenseg_mux_display #(.VALUE_W(8), .DIGITS(2), .REFRESH_DIV(4), .COMMON_ANODE(1'b0)) u_b (
    .clk(clk), .rst(rst), .value(value), .load(load), .mode_dec(mode_dec), .blank_lz(blank_lz),
    .seg(seg_b), .dig_en(dig_en_b), .busy(busy_b), .ovf(ovf_b)
  );

  sevenseg_mux_display #(.VALUE_W(8), .DIGITS(3), .REFRESH_DIV(4), .COMMON_ANODE(1'b1)) u_c (
    .clk(clk), .rst(rst), .value(value), .load(load), .mode_dec(mode_dec), .blank_lz(blank_lz),
    .seg(seg_c), .dig_en(dig_en_c), .busy(busy_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t mk(input int id,
                              input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                              input logic ov3,
                              input logic [6:0] b0, input logic [6:0] b1,
                              input logic ov2, input int bl);
    exp_t e;
    e.g3       = {a2, a1, a0};
    e.ovf3     = ov3;
    e.g2       = {b1, b0};
    e.ovf2     = ov2;
    e.busy_len = bl;
    e.id       = id;
    return e;
  endfunction

  task automatic pulse(input logic [7:0] v, input logic md, input logic bz);
    @(posedge clk);
    #1;
    value    = v;
    mode_dec = md;
    blank_lz = bz;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic issue(input exp_t e, input logic [7:0] v, input logic md, input logic bz);
    exp_q.push_back(e);
    issued++;
    pulse(v, md, bz);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < issued && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt < issued) begin
      failures++;
      $display("FAIL update_timeout: got %0d updates expected %0d", done_cnt, issued);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  // Monitor: one scoreboard entry per visible display update.
  initial begin : monitor
    exp_t e;
    int   ia, ib, ic;
    int   bad_a, bad_b, bad_c, bad_oh;
    int   cnt[3];
    logic o_a, o_b, o_c;
    bit   rst_trig, trig, prev_busy, prev_rst;
    int   busy_run;
    busy_run  = 0;
    prev_busy = 1'b0;
    prev_rst  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rst  = 1'b1;
        prev_busy = 1'b0;
        busy_run  = 0;
      end else begin
        rst_trig = prev_rst;
        trig     = rst_trig || (prev_busy && !busy_a);
        if (busy_a) busy_run++;
        prev_rst  = 1'b0;
        prev_busy = busy_a;
        if (trig) begin
          chk("expect_pending", done_cnt, (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_trig && e.busy_len >= 0) chk("busy_cycles", e.id, busy_run, e.busy_len);
            if (rst_trig) @(negedge clk);
            bad_a = 0; bad_b = 0; bad_c = 0; bad_oh = 0;
            cnt = '{0, 0, 0};
            o_a = ovf_a; o_b = ovf_b; o_c = ovf_c;
            for (int c = 0; c < 12; c++) begin
              if (c > 0) @(negedge clk);
              ia = oh_idx(dig_en_a);
              ib = oh_idx({1'b0, dig_en_b});
              ic = oh_idx(~dig_en_c);
              if (ia < 0 || ib < 0 || ic < 0) bad_oh++;
              if (ia >= 0) begin
                cnt[ia]++;
                if (seg_a !== e.g3[ia]) bad_a++;
              end
              if (ib >= 0 && ib < 2) begin
                if (seg_b !== e.g2[ib]) bad_b++;
              end
              if (ic >= 0) begin
                if (seg_c !== ~e.g3[ic]) bad_c++;
              end
            end
            chk("ovf_3dig",      e.id, o_a, e.ovf3);
            chk("ovf_2dig",      e.id, o_b, e.ovf2);
            chk("ovf_ca",        e.id, o_c, e.ovf3);
            chk("glyph_3dig",    e.id, bad_a, 0);
            chk("glyph_2dig",    e.id, bad_b, 0);
            chk("glyph_ca",      e.id, bad_c, 0);
            chk("dig_en_onehot", e.id, bad_oh, 0);
            chk("dwell_d0",      e.id, cnt[0], 4);
            chk("dwell_d1",      e.id, cnt[1], 4);
            chk("dwell_d2",      e.id, cnt[2], 4);
            done_cnt++;
          end
          busy_run  = 0;
          prev_busy = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    rst      = 1'b1;
    load     = 1'b0;
    value    = 8'd0;
    mode_dec = 1'b0;
    blank_lz = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_seg",       0, seg_a, 7'h00);
    chk("rst_dig_en",    0, dig_en_a, 3'b000);
    chk("rst_seg_ca",    0, seg_c, 7'h7F);
    chk("rst_dig_en_ca", 0, dig_en_c, 3'b111);
    chk("rst_busy",      0, {busy_a, busy_b, busy_c}, 3'b000);
    chk("rst_ovf",       0, {ovf_a, ovf_b, ovf_c}, 3'b000);

    exp_q.push_back(mk(0, 7'h3F, 7'h3F, 7'h3F, 1'b0, 7'h3F, 7'h3F, 1'b0, -1));
    issued++;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done();

    issue(mk(1, 7'h6D, 7'h77, 7'h3F, 1'b0, 7'h6D, 7'h77, 1'b0, 1), 8'hA5, 1'b0, 1'b0);
    wait_done();
    issue(mk(2, 7'h6D, 7'h6D, 7'h5B, 1'b0, 7'h40, 7'h40, 1'b1, 9), 8'd255, 1'b1, 1'b0);
    wait_done();
    issue(mk(3, 7'h07, 7'h00, 7'h00, 1'b0, 7'h07, 7'h00, 1'b0, 9), 8'd7, 1'b1, 1'b1);
    wait_done();
    issue(mk(4, 7'h3F, 7'h00, 7'h00, 1'b0, 7'h3F, 7'h00, 1'b0, 9), 8'd0, 1'b1, 1'b1);
    wait_done();
    issue(mk(5, 7'h3F, 7'h3F, 7'h06, 1'b0, 7'h40, 7'h40, 1'b1, 9), 8'd100, 1'b1, 1'b0);
    wait_done();
    issue(mk(6, 7'h71, 7'h71, 7'h3F, 1'b0, 7'h71, 7'h71, 1'b0, 1), 8'hFF, 1'b0, 1'b0);
    wait_done();

    // A second load during conversion must be ignored.
    issue(mk(7, 7'h3F, 7'h3F, 7'h5B, 1'b0, 7'h40, 7'h40, 1'b1, 9), 8'd200, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    pulse(8'd3, 1'b1, 1'b0);
    wait_done();

    // Reset in the middle of a conversion: no stale commit, display returns to zeros.
    pulse(8'd200, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(mk(8, 7'h3F, 7'h3F, 7'h3F, 1'b0, 7'h3F, 7'h3F, 1'b0, -1));
    issued++;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy",  8, {busy_a, busy_b, busy_c}, 3'b000);
    chk("midrst_ovf",   8, {ovf_a, ovf_b, ovf_c}, 3'b000);
    chk("midrst_seg",   8, seg_a, 7'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done();

    issue(mk(9, 7'h3F, 7'h4F, 7'h00, 1'b0, 7'h3F, 7'h4F, 1'b0, 1), 8'h30, 1'b0, 1'b1);
    wait_done();
    issue(mk(10, 7'h3F, 7'h3F, 7'h06, 1'b0, 7'h40, 7'h40, 1'b1, 9), 8'd100, 1'b1, 1'b1);
    wait_done();
    issue(mk(11, 7'h6D, 7'h00, 7'h00, 1'b0, 7'h6D, 7'h00, 1'b0, 1), 8'h05, 1'b0, 1'b1);
    wait_done();

    repeat (4) @(posedge clk);
    chk("queue_drained", 12, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
